// File: rtl/stream_mux_n_pkg.sv
// rtl/stream_mux_n_pkg.sv - shared select-mode encodings for the stream selector
package stream_mux_n_pkg;

    // Select mode encodings, also decoded by the CPU control path
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_mux_n_if.sv
// rtl/stream_mux_n_if.sv - N-channel input streams plus one registered output stream
interface stream_mux_n_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;

    // Sources and sink side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    // Selector side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// rtl/stream_mux_n_rr_arbiter.sv - combinational round-robin grant search
module rr_arbiter #(
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    gnt,
    output logic                gntVld
);

    int idx;

    // Search upward from the slot after the last winner, wrapping; first requester wins
    always_comb begin
        gnt    = '0;
        gntVld = 1'b0;
        idx    = 0;
        for (int off = 1; off <= CHANNELS; off++) begin
            idx = (int'(ptr) + off) % CHANNELS;
            if (!gntVld && req[idx]) begin
                gntVld = 1'b1;
                gnt    = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - registered N:1 byte-stream selector with index/round-robin select
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    stream_mux_n_if.slave     bus,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic                outValidQ;
    logic [WIDTH-1:0]    outDataQ;
    logic [SEL_W-1:0]    outChanQ;
    logic [SEL_W-1:0]    rrPtr;
    logic [CNT_W-1:0]    xferCnt;
    logic [SEL_W-1:0]    rrGnt;
    logic                rrVld;
    logic [SEL_W-1:0]    grant;
    logic                selHit;
    logic                gntVld;
    logic                load;
    logic [WIDTH-1:0]    gntData;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
        .req    (bus.in_valid),
        .ptr    (rrPtr),
        .gnt    (rrGnt),
        .gntVld (rrVld)
    );

    assign load  = !outValidQ || bus.out_ready;
    assign grant = (mode == MODE_RR) ? rrGnt : sel;

    // Pick the granted channel's valid and data; an out-of-range index matches no channel
    always_comb begin
        selHit  = 1'b0;
        gntData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                selHit  = bus.in_valid[i];
                gntData = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
        gntVld = (mode == MODE_RR) ? rrVld : selHit;
    end

    // Accept strobe goes only to the granted channel, and only when the register can load
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.in_ready[i] = !rst && load && gntVld && (grant == SEL_W'(i));
        end
    end

    // Output register: refill on drain, empty when nothing is granted, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            outChanQ  <= '0;
            rrPtr     <= SEL_W'(CHANNELS - 1);
        end else if (load) begin
            if (gntVld) begin
                outValidQ <= 1'b1;
                outDataQ  <= gntData;
                outChanQ  <= grant;
                if (mode == MODE_RR) begin
                    rrPtr <= grant;
                end
            end else begin
                outValidQ <= 1'b0;
            end
        end
    end

    // Count words taken by the sink; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            xferCnt <= '0;
        end else if (outValidQ && bus.out_ready) begin
            xferCnt <= xferCnt + CNT_W'(1);
        end
    end

    assign bus.out_valid = outValidQ;
    assign bus.out_data  = outDataQ;
    assign bus.out_chan  = outChanQ;
    assign xfer_cnt      = xferCnt;

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - self-checking bench for stream_mux_n against a behavioural model
module tb_stream_mux_n;
    import stream_mux_n_pkg::*;

    logic       clk = 1'b0;
    logic       rst0, mode0;
    logic [1:0] sel0;
    logic [7:0] cnt0;
    logic       rst1, mode1;
    logic [1:0] sel1;
    logic [1:0] cnt1;

    int tests = 0;
    int fails = 0;

    // Model of the 4-channel instance
    bit         mValid;
    logic [7:0] mData;
    int         mChan;
    int         mCnt;
    int         mPtr;

    stream_mux_n_if #(.WIDTH(8), .CHANNELS(4)) bus0 ();
    stream_mux_n_if #(.WIDTH(8), .CHANNELS(3)) bus1 ();

    stream_mux_n #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst0), .mode(mode0), .sel(sel0), .bus(bus0), .xfer_cnt(cnt0)
    );

    stream_mux_n #(.WIDTH(8), .CHANNELS(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst1), .mode(mode1), .sel(sel1), .bus(bus1), .xfer_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic predict(output int g, output bit gv);
        g  = 0;
        gv = 0;
        if (mode0 == MODE_RR) begin
            for (int off = 1; off <= 4; off++) begin
                int idx;
                idx = (mPtr + off) % 4;
                if (!gv && bus0.in_valid[idx]) begin
                    gv = 1;
                    g  = idx;
                end
            end
        end else begin
            g  = int'(sel0);
            gv = bus0.in_valid[g];
        end
    endtask

    // Compare dut0 against the model, then advance one clock and step the model
    task automatic cycle();
        int         g;
        bit         gv;
        bit         ld;
        logic [3:0] expReady;
        #1;
        predict(g, gv);
        ld       = !mValid || bus0.out_ready;
        expReady = (!rst0 && ld && gv) ? (4'b0001 << g) : 4'b0000;
        check("in_ready", 32'(bus0.in_ready), 32'(expReady));
        check("out_valid", 32'(bus0.out_valid), 32'(mValid));
        check("out_data", 32'(bus0.out_data), 32'(mData));
        check("out_chan", 32'(bus0.out_chan), 32'(mChan));
        check("xfer_cnt", 32'(cnt0), 32'(mCnt));
        @(posedge clk);
        if (rst0) begin
            mValid = 0; mData = 8'h00; mChan = 0; mCnt = 0; mPtr = 3;
        end else begin
            if (mValid && bus0.out_ready) mCnt = (mCnt + 1) % 256;
            if (ld) begin
                if (gv) begin
                    mValid = 1;
                    mData  = bus0.in_data[g*8 +: 8];
                    mChan  = g;
                    if (mode0 == MODE_RR) mPtr = g;
                end else begin
                    mValid = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int rrSeq[6];
        int cntSeq[5];
        rrSeq  = '{0, 1, 2, 3, 0, 1};
        cntSeq = '{1, 2, 3, 0, 1};

        rst0 = 1; mode0 = MODE_SEL; sel0 = 0;
        bus0.in_valid = 4'hF; bus0.in_data = 32'h44332211; bus0.out_ready = 1;
        rst1 = 1; mode1 = MODE_SEL; sel1 = 0;
        bus1.in_valid = 3'b000; bus1.in_data = 24'h0; bus1.out_ready = 1;

        // Reset: bring the model into its reset state after the first edge
        @(posedge clk);
        @(negedge clk);
        mValid = 0; mData = 8'h00; mChan = 0; mCnt = 0; mPtr = 3;
        #1 check("rst in_ready", 32'(bus0.in_ready), 32'h0);
        cycle();
        rst0 = 0; bus0.in_valid = 4'h0;
        #1 check("rst out_valid", 32'(bus0.out_valid), 32'h0);
        check("rst xfer_cnt", 32'(cnt0), 32'h0);

        // Explicit select of channel 2
        mode0 = MODE_SEL; sel0 = 2; bus0.in_valid = 4'b0100;
        bus0.in_data = 32'h11A52233; bus0.out_ready = 1;
        #1 check("sel in_ready", 32'(bus0.in_ready), 32'b0100);
        cycle();
        check("sel out_data", 32'(bus0.out_data), 32'hA5);
        check("sel out_chan", 32'(bus0.out_chan), 32'h2);
        bus0.in_valid = 4'h0;
        cycle();
        check("sel xfer_cnt", 32'(cnt0), 32'h1);

        // Round-robin, all requesting
        mode0 = MODE_RR; bus0.in_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr out_chan", 32'(bus0.out_chan), 32'(rrSeq[k]));
        end

        // Backpressure then drain-and-refill
        mode0 = MODE_SEL; sel0 = 1; bus0.in_valid = 4'b0010;
        bus0.in_data = 32'h00003C00; bus0.out_ready = 1;
        cycle();
        bus0.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            mode0 = MODE_RR; sel0 = 2'(k);
            bus0.in_data = 32'h00007700;
            #1 check("stall in_ready", 32'(bus0.in_ready), 32'h0);
            cycle();
            check("stall out_data", 32'(bus0.out_data), 32'h3C);
        end
        mode0 = MODE_SEL; sel0 = 1; bus0.out_ready = 1;
        cycle();
        check("refill out_valid", 32'(bus0.out_valid), 32'h1);
        check("refill out_data", 32'(bus0.out_data), 32'h77);

        // Reset during a stall discards the held word
        bus0.out_ready = 0;
        cycle();
        rst0 = 1;
        cycle();
        rst0 = 0; bus0.in_valid = 4'h0;
        check("rst stall out_valid", 32'(bus0.out_valid), 32'h0);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            rst0 = ($urandom_range(0, 49) == 0);
            mode0 = 1'($urandom);
            sel0 = 2'($urandom);
            bus0.in_valid = 4'($urandom);
            bus0.in_data = $urandom;
            bus0.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Three-channel instance: out-of-range select
        rst0 = 0; bus0.in_valid = 4'h0; bus0.out_ready = 1;
        rst1 = 0; mode1 = MODE_SEL; sel1 = 2;
        bus1.in_valid = 3'b100; bus1.in_data = 24'h5A0000; bus1.out_ready = 0;
        cycle();
        check("c3 out_valid", 32'(bus1.out_valid), 32'h1);
        check("c3 out_chan", 32'(bus1.out_chan), 32'h2);
        sel1 = 3; bus1.in_valid = 3'b111; bus1.out_ready = 1;
        #1 check("c3 oor in_ready", 32'(bus1.in_ready), 32'h0);
        cycle();
        check("c3 drained out_valid", 32'(bus1.out_valid), 32'h0);
        check("c3 xfer_cnt", 32'(cnt1), 32'h1);

        // Two-bit counter wrap
        rst1 = 1;
        cycle();
        rst1 = 0; sel1 = 0; bus1.in_valid = 3'b001; bus1.out_ready = 1;
        cycle();
        check("wrap start", 32'(cnt1), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("wrap xfer_cnt", 32'(cnt1), 32'(cntSeq[k]));
        end
        bus1.out_ready = 0;
        cycle();
        check("c3 stall out_valid", 32'(bus1.out_valid), 32'h1);
        rst1 = 1;
        cycle();
        rst1 = 0; bus1.in_valid = 3'b000;
        check("c3 rst out_valid", 32'(bus1.out_valid), 32'h0);
        check("c3 rst xfer_cnt", 32'(cnt1), 32'h0);
        cycle();
        check("c3 idle out_valid", 32'(bus1.out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
